estacionamiento_ctrl: RTL

ESTACIONAMIENTO_CTRL -- requirements
Module: estacionamiento_ctrl

---
 rtl/estacionamiento_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/estacionamiento_ctrl.sv
// Parking lot controller: occupancy counter plus a shared entry/exit barrier
// arbitrated round robin, with an open-barrier timeout and a closed hold-off.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | barrier closed, waiting for a valid entry/exit request
// OPEN_IN  | barrier open for an entering vehicle, waiting for entrada
// OPEN_OUT | barrier open for an exiting vehicle, waiting for salida
// HOLD     | barrier closed for HOLD cycles, requests ignored
module estacionamiento_ctrl #(
    parameter int CAPACITY = 16,
    parameter int TIMEOUT  = 100,
    parameter int HOLD     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entrada,
    input  logic       salida,
    input  logic       req_in,
    input  logic       req_out,
    output logic       barrera,
    output logic       dir_in,
    output logic [7:0] ocupados,
    output logic       lleno,
    output logic       vacio,
    output logic       timeout,
    output logic       error
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] OPEN_IN  = 2'd1;
    localparam logic [1:0] OPEN_OUT = 2'd2;
    localparam logic [1:0] HOLD_ST  = 2'd3;

    localparam logic [7:0]  CAP        = 8'(CAPACITY);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD - 1);

    logic [1:0]  state;
    logic [15:0] timer;
    logic [7:0]  hold_cnt;
    logic        rr_in;
    logic [7:0]  ocupados_next;
    logic        error_next;
    logic        grant_in;
    logic        grant_out;
    logic        closing;

    // Next occupancy; overflow/underflow attempts hold the count and flag error.
    always_comb begin
        ocupados_next = ocupados;
        error_next    = 1'b0;
        if (entrada && !salida) begin
            if (ocupados == CAP) error_next = 1'b1;
            else                 ocupados_next = ocupados + 8'd1;
        end else if (salida && !entrada) begin
            if (ocupados == 8'd0) error_next = 1'b1;
            else                  ocupados_next = ocupados - 8'd1;
        end
    end

    // Occupancy register with flags derived from the updated count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocupados <= 8'd0;
            lleno    <= 1'b0;
            vacio    <= 1'b1;
            error    <= 1'b0;
        end else begin
            ocupados <= ocupados_next;
            lleno    <= (ocupados_next == CAP);
            vacio    <= (ocupados_next == 8'd0);
            if (error_next) error <= 1'b1;
        end
    end

    // Round robin arbitration; rr_in marks entry as the preferred direction.
    always_comb begin
        grant_in  = req_in && !lleno && (!req_out || rr_in);
        grant_out = req_out && !grant_in;
        closing   = (state == OPEN_IN) ? entrada : salida;
    end

    // Barrier FSM: grant, open with timeout, then fixed closed hold-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            barrera  <= 1'b0;
            dir_in   <= 1'b1;
            timeout  <= 1'b0;
            timer    <= 16'd0;
            hold_cnt <= 8'd0;
            rr_in    <= 1'b1;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_in) begin
                        state   <= OPEN_IN;
                        barrera <= 1'b1;
                        dir_in  <= 1'b1;
                        timer   <= 16'd0;
                        rr_in   <= 1'b0;
                    end else if (grant_out) begin
                        state   <= OPEN_OUT;
                        barrera <= 1'b1;
                        dir_in  <= 1'b0;
                        timer   <= 16'd0;
                        rr_in   <= 1'b1;
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    // The closing pulse takes priority over a simultaneous expiry.
                    if (closing || timer == TIMER_LAST) begin
                        state    <= HOLD_ST;
                        barrera  <= 1'b0;
                        hold_cnt <= HOLD_LAST;
                        timeout  <= !closing;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                HOLD_ST: begin
                    if (hold_cnt == 8'd0) state <= IDLE;
                    else                  hold_cnt <= hold_cnt - 8'd1;
                end
                default: begin
                    state   <= IDLE;
                    barrera <= 1'b0;
                end
            endcase
        end
    end

endmodule
